// File: rtl/bam_err_monitor.sv
// Error-statistics collector for the 8x8 broken-array approximate multipliers.
// Compares each accepted approximate product with the exact product and accumulates frame statistics.
module bam_err_monitor #(
    parameter int N_SAMPLES = 256,
    parameter int CNT_W     = 16,
    parameter int SUM_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    input  logic [15:0]       approx_p,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_count,
    output logic [CNT_W-1:0]  res_mismatch,
    output logic [SUM_W-1:0]  res_err_sum,
    output logic [15:0]       res_err_max,
    output logic              res_neg,
    output logic              res_sat
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    // Magnitude of a 17-bit two's-complement difference; always fits in 16 bits.
    function automatic logic [15:0] abs_diff(input logic [16:0] d);
        logic [16:0] neg_d;
        neg_d = 17'd0 - d;
        if (d[16]) begin
            abs_diff = neg_d[15:0];
        end else begin
            abs_diff = d[15:0];
        end
    endfunction

    // Saturating add; bit SUM_W of the result flags that saturation occurred.
    function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] acc, input logic [15:0] inc);
        logic [SUM_W:0] s;
        s = {1'b0, acc} + {{(SUM_W-15){1'b0}}, inc};
        if (s[SUM_W]) begin
            sat_add = {1'b1, {SUM_W{1'b1}}};
        end else begin
            sat_add = s;
        end
    endfunction

    state_t             r_state;
    state_t             w_next_state;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_res_valid;
    logic [CNT_W-1:0]   r_in_cnt;

    logic               r_s1_valid;
    logic [7:0]         r_s1_a;
    logic [7:0]         r_s1_b;
    logic [15:0]        r_s1_p;
    logic               r_s2_valid;
    logic [15:0]        r_s2_abs;
    logic               r_s2_neg;

    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_mismatch;
    logic [SUM_W-1:0]   r_err_sum;
    logic [15:0]        r_err_max;
    logic               r_neg;
    logic               r_sat;

    logic               w_accept;
    logic               w_last;
    logic               w_frame_open;
    logic [15:0]        w_exact;
    logic [16:0]        w_diff;
    logic [SUM_W:0]     w_sum_next;

    assign w_accept     = in_valid & r_in_ready;
    assign w_last       = (r_in_cnt == LAST_IDX);
    assign w_frame_open = (r_state == ST_IDLE) & start;
    assign w_exact      = 16'(r_s1_a) * 16'(r_s1_b);
    assign w_diff       = {1'b0, w_exact} - {1'b0, r_s1_p};
    assign w_sum_next   = sat_add(r_err_sum, r_s2_abs);

    // Next-state decode for the frame FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_RUN;
                else       w_next_state = ST_IDLE;
            end
            ST_RUN: begin
                if (w_accept && w_last) w_next_state = ST_DRAIN;
                else                    w_next_state = ST_RUN;
            end
            ST_DRAIN: begin
                // Leave only once both pipeline stages have retired into the accumulators.
                if (!r_s1_valid && !r_s2_valid) w_next_state = ST_DONE;
                else                            w_next_state = ST_DRAIN;
            end
            ST_DONE: begin
                if (res_ready) w_next_state = ST_IDLE;
                else           w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state == ST_RUN);
            r_busy      <= (w_next_state == ST_RUN) || (w_next_state == ST_DRAIN);
            r_res_valid <= (w_next_state == ST_DONE);
        end
    end

    // Count of accepted samples, used to find the last sample of the frame.
    always_ff @(posedge clk) begin
        if (rst || w_frame_open) begin
            r_in_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_in_cnt <= r_in_cnt + CNT_W'(1);
        end
    end

    // Stage 1: capture the accepted operands and approximate product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= 8'd0;
            r_s1_b     <= 8'd0;
            r_s1_p     <= 16'd0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a <= a;
                r_s1_b <= b;
                r_s1_p <= approx_p;
            end
        end
    end

    // Stage 2: exact product, signed difference reduced to magnitude and sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_abs   <= 16'd0;
            r_s2_neg   <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_abs   <= abs_diff(w_diff);
            r_s2_neg   <= w_diff[16];
        end
    end

    // Frame accumulators; cleared when a frame opens, otherwise held for readout.
    always_ff @(posedge clk) begin
        if (rst || w_frame_open) begin
            r_count    <= {CNT_W{1'b0}};
            r_mismatch <= {CNT_W{1'b0}};
            r_err_sum  <= {SUM_W{1'b0}};
            r_err_max  <= 16'd0;
            r_neg      <= 1'b0;
            r_sat      <= 1'b0;
        end else if (r_s2_valid) begin
            r_count    <= r_count + CNT_W'(1);
            r_mismatch <= r_mismatch + CNT_W'(r_s2_abs != 16'd0);
            r_err_sum  <= w_sum_next[SUM_W-1:0];
            r_sat      <= r_sat | w_sum_next[SUM_W];
            if (r_s2_abs > r_err_max) begin
                r_err_max <= r_s2_abs;
            end
            r_neg      <= r_neg | r_s2_neg;
        end
    end

    assign in_ready     = r_in_ready;
    assign busy         = r_busy;
    assign res_valid    = r_res_valid;
    assign res_count    = r_count;
    assign res_mismatch = r_mismatch;
    assign res_err_sum  = r_err_sum;
    assign res_err_max  = r_err_max;
    assign res_neg      = r_neg;
    assign res_sat      = r_sat;

endmodule

// File: tb/tb_bam_err_monitor.sv
// Directed bench for bam_err_monitor: three instances (N=4/SUM_W=32, N=1, N=4/SUM_W=16)
// share stimulus inputs; each has its own start pulse.
module tb_bam_err_monitor;

    logic        clk;
    logic        rst;
    logic [2:0]  start_v;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] approx_p;
    logic        res_ready;

    logic        ir_o   [3];
    logic        busy_o [3];
    logic        rv_o   [3];
    logic [15:0] cnt_o  [3];
    logic [15:0] mis_o  [3];
    logic [15:0] max_o  [3];
    logic        neg_o  [3];
    logic        sat_o  [3];
    logic [31:0] sum_a;
    logic [31:0] sum_b;
    logic [15:0] sum_c;

    int checks;
    int failures;
    int lat;

    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [15:0] vp [4];

    bam_err_monitor #(.N_SAMPLES(4), .CNT_W(16), .SUM_W(32)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_ready(ir_o[0]),
        .a(a), .b(b), .approx_p(approx_p), .busy(busy_o[0]), .res_valid(rv_o[0]),
        .res_ready(res_ready), .res_count(cnt_o[0]), .res_mismatch(mis_o[0]),
        .res_err_sum(sum_a), .res_err_max(max_o[0]), .res_neg(neg_o[0]), .res_sat(sat_o[0])
    );

    bam_err_monitor #(.N_SAMPLES(1), .CNT_W(16), .SUM_W(32)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_ready(ir_o[1]),
        .a(a), .b(b), .approx_p(approx_p), .busy(busy_o[1]), .res_valid(rv_o[1]),
        .res_ready(res_ready), .res_count(cnt_o[1]), .res_mismatch(mis_o[1]),
        .res_err_sum(sum_b), .res_err_max(max_o[1]), .res_neg(neg_o[1]), .res_sat(sat_o[1])
    );

    bam_err_monitor #(.N_SAMPLES(4), .CNT_W(16), .SUM_W(16)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_ready(ir_o[2]),
        .a(a), .b(b), .approx_p(approx_p), .busy(busy_o[2]), .res_valid(rv_o[2]),
        .res_ready(res_ready), .res_count(cnt_o[2]), .res_mismatch(mis_o[2]),
        .res_err_sum(sum_c), .res_err_max(max_o[2]), .res_neg(neg_o[2]), .res_sat(sat_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sumv(input int inst);
        case (inst)
            0:       sumv = {32'd0, sum_a};
            1:       sumv = {32'd0, sum_b};
            default: sumv = {48'd0, sum_c};
        endcase
    endfunction

    task automatic check_res(input int inst, input string tag, input logic [15:0] e_cnt,
                             input logic [15:0] e_mis, input logic [31:0] e_sum,
                             input logic [15:0] e_max, input logic e_neg, input logic e_sat);
        chk({tag, ".count"},    {48'd0, cnt_o[inst]}, {48'd0, e_cnt});
        chk({tag, ".mismatch"}, {48'd0, mis_o[inst]}, {48'd0, e_mis});
        chk({tag, ".err_sum"},  sumv(inst),           {32'd0, e_sum});
        chk({tag, ".err_max"},  {48'd0, max_o[inst]}, {48'd0, e_max});
        chk({tag, ".neg"},      {63'd0, neg_o[inst]}, {63'd0, e_neg});
        chk({tag, ".sat"},      {63'd0, sat_o[inst]}, {63'd0, e_sat});
    endtask

    // Opens a frame on one instance, feeds n samples from va/vb/vp, then waits for res_valid.
    task automatic run_frame(input int inst, input int n, input bit gaps, output int latency);
        start_v = 3'b000;
        start_v[inst] = 1'b1;
        tick();
        start_v = 3'b000;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            a        = va[i];
            b        = vb[i];
            approx_p = vp[i];
            tick();
        end
        in_valid = 1'b0;
        latency  = 0;
        while (!rv_o[inst] && latency < 20) begin
            tick();
            latency++;
        end
    endtask

    task automatic handshake(input int inst, input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, ".hs_res_valid"}, {63'd0, rv_o[inst]},   64'd0);
        chk({tag, ".hs_busy"},      {63'd0, busy_o[inst]}, 64'd0);
    endtask

    task automatic load_exact();
        va[0] = 8'd255; vb[0] = 8'd255; vp[0] = 16'hFE01;
        va[1] = 8'd0;   vb[1] = 8'd7;   vp[1] = 16'd0;
        va[2] = 8'd3;   vb[2] = 8'd5;   vp[2] = 16'd15;
        va[3] = 8'd16;  vb[3] = 8'd16;  vp[3] = 16'd256;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start_v   = 3'b000;
        in_valid  = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        approx_p  = 16'd0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            check_res(i, $sformatf("reset%0d", i), 16'd0, 16'd0, 32'd0, 16'd0, 1'b0, 1'b0);
            chk($sformatf("reset%0d.in_ready", i),  {63'd0, ir_o[i]},   64'd0);
            chk($sformatf("reset%0d.busy", i),      {63'd0, busy_o[i]}, 64'd0);
            chk($sformatf("reset%0d.res_valid", i), {63'd0, rv_o[i]},   64'd0);
        end

        // Samples offered in IDLE must be ignored.
        in_valid = 1'b1; a = 8'd3; b = 8'd5; approx_p = 16'd0;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("idle_ignore.count", {48'd0, cnt_o[0]}, 64'd0);
        chk("idle_ignore.in_ready", {63'd0, ir_o[0]}, 64'd0);

        // Exact frame.
        load_exact();
        run_frame(0, 4, 1'b0, lat);
        chk("exact.latency", 64'(lat), 64'd3);
        check_res(0, "exact", 16'd4, 16'd0, 32'd0, 16'd0, 1'b0, 1'b0);
        chk("exact.busy_done", {63'd0, busy_o[0]}, 64'd0);
        handshake(0, "exact");

        // Frame with two mismatches: |15-0| + |65025-49152| = 15 + 15873.
        va[0] = 8'd3;   vb[0] = 8'd5;   vp[0] = 16'd0;
        va[1] = 8'd255; vb[1] = 8'd255; vp[1] = 16'hC000;
        va[2] = 8'd16;  vb[2] = 8'd16;  vp[2] = 16'd256;
        va[3] = 8'd0;   vb[3] = 8'd7;   vp[3] = 16'd0;
        run_frame(0, 4, 1'b0, lat);
        chk("mism.latency", 64'(lat), 64'd3);
        check_res(0, "mism", 16'd4, 16'd2, 32'd15888, 16'h3E01, 1'b0, 1'b0);
        handshake(0, "mism");

        // Single-sample frame where approx exceeds exact: 1*1 - 3 = -2.
        va[0] = 8'd1; vb[0] = 8'd1; vp[0] = 16'd3;
        run_frame(1, 1, 1'b0, lat);
        chk("n1.latency", 64'(lat), 64'd3);
        check_res(1, "n1", 16'd1, 16'd1, 32'd2, 16'd2, 1'b1, 1'b0);
        handshake(1, "n1");

        // Results held in DONE while res_ready is low; start is ignored there.
        load_exact();
        run_frame(0, 4, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) start_v[0] = 1'b1;
            tick();
            start_v[0] = 1'b0;
            chk($sformatf("hold%0d.res_valid", i), {63'd0, rv_o[0]}, 64'd1);
            chk($sformatf("hold%0d.in_ready", i),  {63'd0, ir_o[0]}, 64'd0);
            chk($sformatf("hold%0d.count", i),     {48'd0, cnt_o[0]}, 64'd4);
        end
        check_res(0, "hold", 16'd4, 16'd0, 32'd0, 16'd0, 1'b0, 1'b0);
        handshake(0, "hold");
        check_res(0, "hold_idle", 16'd4, 16'd0, 32'd0, 16'd0, 1'b0, 1'b0);

        // Reset in RUN after two accepted samples discards the frame.
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        in_valid = 1'b1; a = 8'd255; b = 8'd255; approx_p = 16'd0;
        tick();
        tick();
        in_valid = 1'b0;
        chk("abort.busy_before", {63'd0, busy_o[0]}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_res(0, "abort", 16'd0, 16'd0, 32'd0, 16'd0, 1'b0, 1'b0);
        chk("abort.busy",      {63'd0, busy_o[0]}, 64'd0);
        chk("abort.in_ready",  {63'd0, ir_o[0]},   64'd0);
        chk("abort.res_valid", {63'd0, rv_o[0]},   64'd0);
        tick();
        tick();
        check_res(0, "abort_flush", 16'd0, 16'd0, 32'd0, 16'd0, 1'b0, 1'b0);
        load_exact();
        run_frame(0, 4, 1'b0, lat);
        check_res(0, "after_abort", 16'd4, 16'd0, 32'd0, 16'd0, 1'b0, 1'b0);
        handshake(0, "after_abort");

        // 16-bit sum saturates: 4 * 65025 exceeds 0xFFFF.
        for (int i = 0; i < 4; i++) begin
            va[i] = 8'd255; vb[i] = 8'd255; vp[i] = 16'd0;
        end
        run_frame(2, 4, 1'b0, lat);
        chk("sat.latency", 64'(lat), 64'd3);
        check_res(2, "sat", 16'd4, 16'd4, 32'h0000FFFF, 16'hFE01, 1'b0, 1'b1);
        handshake(2, "sat");

        run_frame(2, 4, 1'b1, lat);
        chk("sat_gaps.latency", 64'(lat), 64'd3);
        check_res(2, "sat_gaps", 16'd4, 16'd4, 32'h0000FFFF, 16'hFE01, 1'b0, 1'b1);
        handshake(2, "sat_gaps");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bam_err_monitor.md
# bam_err_monitor

Sequential error-statistics collector that sits directly downstream of the 8x8 unsigned broken-array approximate multipliers. For each accepted operand pair it recomputes the exact product and compares it with the approximate product supplied by the multiplier. Over a frame of N samples it accumulates the sample count, mismatch count, error sum and maximum error. Results are returned through a valid/ready handshake and drive hardware-in-the-loop characterisation of the h/v truncation variants.

## Interface
Parameters:
- N_SAMPLES, 256: samples per frame; legal range 1 to 2^CNT_W-1.
- CNT_W, 16: width of the count and mismatch counters.
- SUM_W, 32: width of the error-sum accumulator; minimum 16.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle pulse that opens a frame; honoured only in IDLE.
- in_valid  in  1  operand sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- a  in  8  multiplicand (unsigned).
- b  in  8  multiplier (unsigned).
- approx_p  in  16  approximate product from the upstream multiplier.
- busy  out  1  high in RUN and DRAIN.
- res_valid  out  1  frame results valid.
- res_ready  in  1  consumer takes the results.
- res_count  out  CNT_W  samples accepted in the frame.
- res_mismatch  out  CNT_W  samples with approx_p != a*b.
- res_err_sum  out  SUM_W  sum of |a*b - approx_p|, saturating.
- res_err_max  out  16  maximum |a*b - approx_p|.
- res_neg  out  1  at least one sample had approx_p > a*b.
- res_sat  out  1  res_err_sum saturated.

## Operation
- A sample is accepted when in_valid and in_ready are both 1.
- FSM states and transitions:
  - IDLE: in_ready=0. start moves to RUN and clears all accumulators the same edge.
  - RUN: in_ready=1. The edge that accepts sample number N_SAMPLES moves to DRAIN.
  - DRAIN: in_ready=0. Waits until the pipeline is empty (exactly 2 cycles), then moves to DONE.
  - DONE: res_valid=1. res_valid and res_ready both 1 moves to IDLE.
- start outside IDLE is ignored. In IDLE, in_valid is ignored.
- Pipeline:
  - S1 registers a, b, approx_p and the valid bit.
  - S2 computes exact = a*b (16 bit) and diff = exact - approx_p (17 bit signed), then registers |diff| (16 bit), the sign and the valid bit.
  - Accumulate stage on S2 valid:
    - count += 1.
    - mismatch += (|diff| != 0).
    - err_sum += |diff|, saturating at 2^SUM_W-1 and setting sat.
    - err_max = max(err_max, |diff|).
    - neg |= sign.
- Counters do not wrap because N_SAMPLES is bounded by the parameter range.
- Result outputs are the accumulator registers. They are stable from entry to DONE until the next start clears them, so they are held in IDLE after the handshake.
- in_valid=1 with in_ready=0 is neither consumed nor buffered.

## Timing
- Reset: state IDLE. Outputs after reset:
  - in_ready=0, busy=0, res_valid=0.
  - res_count, res_mismatch, res_err_sum and res_err_max all 0.
  - res_neg=0, res_sat=0.
  - Pipeline valid bits are cleared.
- rst mid-frame in any state aborts the frame on that edge and discards in-flight samples.
- Sample latency: a sample accepted at edge k updates the accumulators at edge k+2.
- start at edge t gives in_ready=1 from cycle t+1.
- res_valid rises 3 edges after the last acceptance: 2 drain cycles plus the DONE entry.
- Throughput is one sample per cycle with no bubbles in RUN.
- A handshake at edge d drops res_valid after d. start is honoured from the next cycle in IDLE.

## Test plan
- N=4, four exact pairs ((255,255,0xFE01), (0,7,0), (3,5,15), (16,16,256)) → count 4, mismatch 0, sum 0, max 0, neg 0, sat 0.
- N=4 with mismatches: (3,5,approx 0) and (255,255,approx 0xC000), plus two exact pairs → mismatch 2, sum 15888, max 15873 (0x3E01), neg 0.
- N=1, sample (1,1,approx 3) → mismatch 1, sum 2, max 2, neg 1.
- N=4, res_ready held low 10 cycles in DONE → res_valid and all results stable, in_ready 0; a start pulse has no effect. res_ready=1 → IDLE next cycle.
- rst asserted in RUN after 2 accepted samples, then a fresh N=4 exact frame → after reset all outputs 0 and state IDLE; the new frame reports count 4, sum 0 with no stale contribution.
- SUM_W=16, N=4, each sample (255,255,approx 0) → sum 0xFFFF, sat 1, max 0xFE01, mismatch 4. Repeat with in_valid toggling every other cycle → identical results, res_valid 3 edges after the 4th acceptance.
